// File: rtl/mem_port_arbiter.sv
// Arbitrates a single-ported RAM between instruction fetch (IF) and the memory stage (MEM).
// MEM wins contested grants until IF has lost STARVE_MAX times in a row.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_done,
  output logic              if_stall,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic              mem_gnt,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              mem_done,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  input  logic              ram_ready
);

  localparam logic [3:0] StarveMax = 4'(STARVE_MAX);

  typedef enum logic [1:0] {StIdle, StBusyIf, StBusyMem} state_e;

  state_e     state_q;
  logic [3:0] starve_q;

  logic if_elig;
  logic mem_elig;
  logic grant_mem;
  logic grant_if;

  // A requester is never re-granted in the cycle its done pulse is visible.
  always_comb begin
    if_elig   = if_req & ~if_done;
    mem_elig  = mem_req & ~mem_done;
    grant_mem = mem_elig & ~(if_elig & (starve_q == StarveMax));
    grant_if  = if_elig & ~grant_mem;
  end

  assign if_stall = if_req & ~if_done;

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q   <= StIdle;
      starve_q  <= 4'd0;
      if_gnt    <= 1'b0;
      if_done   <= 1'b0;
      if_rdata  <= '0;
      mem_gnt   <= 1'b0;
      mem_done  <= 1'b0;
      mem_rdata <= '0;
      ram_en    <= 1'b0;
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
    end else begin
      if_gnt   <= 1'b0;
      if_done  <= 1'b0;
      mem_gnt  <= 1'b0;
      mem_done <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (grant_mem) begin
            mem_gnt   <= 1'b1;
            ram_en    <= 1'b1;
            ram_we    <= mem_we;
            ram_addr  <= mem_addr;
            ram_wdata <= mem_wdata;
            state_q   <= StBusyMem;
            if (if_elig && (starve_q < StarveMax)) begin
              starve_q <= 4'(starve_q + 4'd1);
            end
          end else if (grant_if) begin
            if_gnt    <= 1'b1;
            ram_en    <= 1'b1;
            ram_we    <= 1'b0;
            ram_addr  <= if_addr;
            ram_wdata <= '0;
            state_q   <= StBusyIf;
            starve_q  <= 4'd0;
          end
        end
        StBusyIf: begin
          if (ram_ready) begin
            if_rdata <= ram_rdata;
            if_done  <= 1'b1;
            ram_en   <= 1'b0;
            ram_we   <= 1'b0;
            state_q  <= StIdle;
          end
        end
        StBusyMem: begin
          if (ram_ready) begin
            // The registered strobe still tells a read from a write here.
            if (!ram_we) begin
              mem_rdata <= ram_rdata;
            end
            mem_done <= 1'b1;
            ram_en   <= 1'b0;
            ram_we   <= 1'b0;
            state_q  <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: a RAM responder with programmable latency,
// a scoreboard of expected grants and read data, and one task per scenario.
module tb_mem_port_arbiter;

  localparam int GIf  = 1;
  localparam int GMem = 2;

  logic        clock;
  logic        reset;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt;
  logic [31:0] if_rdata;
  logic        if_done;
  logic        if_stall;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_gnt;
  logic [31:0] mem_rdata;
  logic        mem_done;
  logic        ram_en;
  logic        ram_we;
  logic [31:0] ram_addr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;
  logic        ram_ready;

  int tests_run    = 0;
  int tests_failed = 0;

  int          gnt_q[$];
  logic [31:0] if_q[$];
  logic [31:0] mem_q[$];
  logic [31:0] exp_mem_rdata;
  bit          mon_on = 0;

  int lat         = 0;
  int cnt         = 0;
  bit ready_force = 0;

  mem_port_arbiter #(
    .ADDR_W    (32),
    .DATA_W    (32),
    .STARVE_MAX(4)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .if_req   (if_req),
    .if_addr  (if_addr),
    .if_gnt   (if_gnt),
    .if_rdata (if_rdata),
    .if_done  (if_done),
    .if_stall (if_stall),
    .mem_req  (mem_req),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_gnt  (mem_gnt),
    .mem_rdata(mem_rdata),
    .mem_done (mem_done),
    .ram_en   (ram_en),
    .ram_we   (ram_we),
    .ram_addr (ram_addr),
    .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata),
    .ram_ready(ram_ready)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [31:0] rdata_of(input logic [31:0] a);
    if (a == 32'h40) return 32'hDEAD_BEEF;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_5A5A;
  endfunction

  // RAM responder: ready rises after lat stalled cycles; data is garbage until ready.
  assign ram_rdata = ram_ready ? rdata_of(ram_addr) : ~rdata_of(ram_addr);

  always @(negedge clock) begin
    if (ready_force) begin
      ram_ready <= 1'b1;
      cnt       <= 0;
    end else if (ram_en === 1'b1) begin
      ram_ready <= (cnt == lat);
      cnt       <= cnt + 1;
    end else begin
      ram_ready <= 1'b0;
      cnt       <= 0;
    end
  end

  // Scoreboard monitor: grant order and completion data.
  always @(negedge clock) begin
    if (mon_on) begin
      if (if_gnt === 1'b1) begin
        tests_run++;
        if (gnt_q.size() == 0 || gnt_q[0] != GIf) begin
          tests_failed++;
          $display("FAIL grant_order: got if_gnt, expected %0d (1=IF 2=MEM 0=none)",
                   gnt_q.size() ? gnt_q[0] : 0);
        end
        if (gnt_q.size() != 0) void'(gnt_q.pop_front());
      end
      if (mem_gnt === 1'b1) begin
        tests_run++;
        if (gnt_q.size() == 0 || gnt_q[0] != GMem) begin
          tests_failed++;
          $display("FAIL grant_order: got mem_gnt, expected %0d (1=IF 2=MEM 0=none)",
                   gnt_q.size() ? gnt_q[0] : 0);
        end
        if (gnt_q.size() != 0) void'(gnt_q.pop_front());
      end
      if (if_done === 1'b1) begin
        tests_run++;
        if (if_q.size() == 0) begin
          tests_failed++;
          $display("FAIL if_done_unexpected: got if_done=1, required none pending");
        end else begin
          logic [31:0] e;
          e = if_q.pop_front();
          if (if_rdata !== e) begin
            tests_failed++;
            $display("FAIL if_rdata: got %h, required %h", if_rdata, e);
          end
        end
      end
      if (mem_done === 1'b1) begin
        tests_run++;
        if (mem_q.size() == 0) begin
          tests_failed++;
          $display("FAIL mem_done_unexpected: got mem_done=1, required none pending");
        end else begin
          logic [31:0] e;
          e = mem_q.pop_front();
          if (mem_rdata !== e) begin
            tests_failed++;
            $display("FAIL mem_rdata: got %h, required %h", mem_rdata, e);
          end
        end
      end
      if (ram_we === 1'b1 && ram_en !== 1'b1) begin
        tests_run++;
        tests_failed++;
        $display("FAIL ram_we_without_en: got ram_we=1 ram_en=%b, required ram_en=1", ram_en);
      end
      if ((if_gnt === 1'b1 && if_done === 1'b1) || (mem_gnt === 1'b1 && mem_done === 1'b1)) begin
        tests_run++;
        tests_failed++;
        $display("FAIL gnt_done_overlap: got if %b%b mem %b%b, required never both",
                 if_gnt, if_done, mem_gnt, mem_done);
      end
    end
  end

  function automatic logic flag_of(input int sel);
    case (sel)
      0:       return if_gnt;
      1:       return if_done;
      2:       return mem_gnt;
      default: return mem_done;
    endcase
  endfunction

  // Bounded wait for an output pulse (0 if_gnt, 1 if_done, 2 mem_gnt, 3 mem_done).
  task automatic wait_flag(input int sel, input int budget, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clock);
      if (flag_of(sel) === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset       = 1'b0;
    if_req      = 1'b0;
    if_addr     = '0;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    ready_force = 1'b1;
    @(posedge clock);
    @(posedge clock);
    @(negedge clock);
    tests_run++;
    if ({if_gnt, if_done, mem_gnt, mem_done, ram_en, ram_we} !== 6'b0) begin
      tests_failed++;
      $display("FAIL reset_ctrl: got %b, required 000000",
               {if_gnt, if_done, mem_gnt, mem_done, ram_en, ram_we});
    end
    tests_run++;
    if (if_rdata !== '0 || mem_rdata !== '0 || ram_addr !== '0 || ram_wdata !== '0) begin
      tests_failed++;
      $display("FAIL reset_data: got %h %h %h %h, required all 0",
               if_rdata, mem_rdata, ram_addr, ram_wdata);
    end
    tests_run++;
    if (if_stall !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_stall: got %b, required 0", if_stall);
    end
    reset         = 1'b1;
    ready_force   = 1'b0;
    exp_mem_rdata = '0;
    mon_on        = 1'b1;
    @(negedge clock);
    tests_run++;
    if ({if_gnt, mem_gnt, ram_en} !== 3'b0) begin
      tests_failed++;
      $display("FAIL idle_ignores_ready: got %b, required 000", {if_gnt, mem_gnt, ram_en});
    end
  endtask

  task automatic test_if_alone();
    lat     = 2;
    if_addr = 32'h40;
    if_req  = 1'b1;
    gnt_q.push_back(GIf);
    if_q.push_back(32'hDEAD_BEEF);
    for (int k = 0; k <= 4; k++) begin
      if (k > 0) @(negedge clock);
      else #1;
      tests_run++;
      if (if_gnt !== 1'(k == 1)) begin
        tests_failed++;
        $display("FAIL if_alone_gnt@+%0d: got %b, required %b", k, if_gnt, k == 1);
      end
      tests_run++;
      if (if_done !== 1'(k == 4)) begin
        tests_failed++;
        $display("FAIL if_alone_done@+%0d: got %b, required %b", k, if_done, k == 4);
      end
      tests_run++;
      if (if_stall !== 1'(k < 4)) begin
        tests_failed++;
        $display("FAIL if_alone_stall@+%0d: got %b, required %b", k, if_stall, k < 4);
      end
      if (k == 1) begin
        tests_run++;
        if (ram_en !== 1'b1 || ram_we !== 1'b0 || ram_addr !== 32'h40) begin
          tests_failed++;
          $display("FAIL if_alone_ram: got en=%b we=%b addr=%h, required 1 0 00000040",
                   ram_en, ram_we, ram_addr);
        end
      end
    end
    tests_run++;
    if (if_rdata !== 32'hDEAD_BEEF) begin
      tests_failed++;
      $display("FAIL if_alone_rdata: got %h, required deadbeef", if_rdata);
    end
    if_req = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_mem_write();
    bit seen;
    bit held_ok;
    lat       = 3;
    mem_we    = 1'b1;
    mem_addr  = 32'h100;
    mem_wdata = 32'h1234;
    mem_req   = 1'b1;
    gnt_q.push_back(GMem);
    mem_q.push_back(exp_mem_rdata);
    wait_flag(2, 4, seen);
    tests_run++;
    if (!seen) begin
      tests_failed++;
      $display("FAIL mem_write_gnt: got no mem_gnt in 4 cycles, required one");
    end
    held_ok = 1'b1;
    for (int i = 0; i < 12; i++) begin
      if (ram_en !== 1'b1 || ram_we !== 1'b1 || ram_addr !== 32'h100 || ram_wdata !== 32'h1234)
        held_ok = 1'b0;
      @(negedge clock);
      if (mem_done === 1'b1) break;
    end
    tests_run++;
    if (!held_ok) begin
      tests_failed++;
      $display("FAIL mem_write_hold: got ram bus changing, required en=1 we=1 100/1234 held");
    end
    tests_run++;
    if (mem_done !== 1'b1 || ram_en !== 1'b0 || ram_we !== 1'b0) begin
      tests_failed++;
      $display("FAIL mem_write_done: got done=%b en=%b we=%b, required 1 0 0",
               mem_done, ram_en, ram_we);
    end
    mem_req = 1'b0;
    mem_we  = 1'b0;
    @(negedge clock);
  endtask

  // Contested rounds: IF loses four times, then is forced through, then MEM wins again.
  task automatic test_contention();
    bit seen;
    for (int r = 0; r < 6; r++) begin
      bit win_if;
      win_if   = (r == 4);
      lat      = r % 3;
      mem_we   = 1'b0;
      mem_addr = 32'h200 + 32'(4 * r);
      if_addr  = 32'h80 + 32'(4 * r);
      mem_req  = 1'b1;
      if_req   = 1'b1;
      if (win_if) begin
        gnt_q.push_back(GIf);
        if_q.push_back(rdata_of(if_addr));
      end else begin
        gnt_q.push_back(GMem);
        exp_mem_rdata = rdata_of(mem_addr);
        mem_q.push_back(exp_mem_rdata);
      end
      wait_flag(win_if ? 0 : 2, 3, seen);
      tests_run++;
      if (!seen) begin
        tests_failed++;
        $display("FAIL contend_gnt r%0d: got no %s grant, required one", r,
                 win_if ? "IF" : "MEM");
      end
      if (win_if) begin
        mem_req = 1'b0;
        wait_flag(1, 10, seen);
        if_req = 1'b0;
      end else begin
        if_req = 1'b0;
        wait_flag(3, 10, seen);
        mem_req = 1'b0;
      end
      tests_run++;
      if (!seen) begin
        tests_failed++;
        $display("FAIL contend_done r%0d: got no done, required one", r);
      end
      @(negedge clock);
    end
  endtask

  task automatic test_back_to_back();
    bit seen;
    lat      = 1;
    mem_we   = 1'b0;
    mem_addr = 32'h300;
    if_addr  = 32'h90;
    mem_req  = 1'b1;
    gnt_q.push_back(GMem);
    gnt_q.push_back(GIf);
    gnt_q.push_back(GMem);
    exp_mem_rdata = rdata_of(32'h300);
    mem_q.push_back(exp_mem_rdata);
    if_q.push_back(rdata_of(32'h90));
    mem_q.push_back(exp_mem_rdata);
    wait_flag(2, 3, seen);
    if_req = 1'b1;
    wait_flag(3, 6, seen);
    tests_run++;
    if (!seen || if_gnt !== 1'b0) begin
      tests_failed++;
      $display("FAIL b2b_mem_done: got seen=%b if_gnt=%b, required 1 0", seen, if_gnt);
    end
    @(negedge clock);
    tests_run++;
    if (if_gnt !== 1'b1 || mem_gnt !== 1'b0) begin
      tests_failed++;
      $display("FAIL b2b_if_next: got if_gnt=%b mem_gnt=%b, required 1 0", if_gnt, mem_gnt);
    end
    wait_flag(1, 6, seen);
    if_req = 1'b0;
    @(negedge clock);
    tests_run++;
    if (mem_gnt !== 1'b1) begin
      tests_failed++;
      $display("FAIL b2b_mem_after_if: got mem_gnt=%b, required 1", mem_gnt);
    end
    wait_flag(3, 6, seen);
    mem_req = 1'b0;
    tests_run++;
    if (!seen) begin
      tests_failed++;
      $display("FAIL b2b_final_done: got no mem_done, required one");
    end
    @(negedge clock);
  endtask

  task automatic test_reset_mid_busy();
    bit seen;
    lat      = 6;
    mem_we   = 1'b0;
    mem_addr = 32'h400;
    mem_req  = 1'b1;
    gnt_q.push_back(GMem);
    wait_flag(2, 3, seen);
    @(negedge clock);
    reset   = 1'b0;
    mem_req = 1'b0;
    @(negedge clock);
    reset         = 1'b1;
    exp_mem_rdata = '0;
    tests_run++;
    if ({ram_en, ram_we, mem_done, mem_gnt} !== 4'b0 || mem_rdata !== '0) begin
      tests_failed++;
      $display("FAIL midbusy_reset: got en/we/done/gnt=%b rdata=%h, required 0000 0",
               {ram_en, ram_we, mem_done, mem_gnt}, mem_rdata);
    end
    repeat (8) @(negedge clock);
    lat      = 0;
    mem_addr = 32'h404;
    mem_req  = 1'b1;
    gnt_q.push_back(GMem);
    exp_mem_rdata = rdata_of(32'h404);
    mem_q.push_back(exp_mem_rdata);
    @(negedge clock);
    tests_run++;
    if (mem_gnt !== 1'b1 || ram_addr !== 32'h404) begin
      tests_failed++;
      $display("FAIL post_reset_gnt: got gnt=%b addr=%h, required 1 00000404", mem_gnt, ram_addr);
    end
    wait_flag(3, 4, seen);
    mem_req = 1'b0;
    tests_run++;
    if (!seen) begin
      tests_failed++;
      $display("FAIL post_reset_done: got no mem_done, required one");
    end
    repeat (2) @(negedge clock);
  endtask

  initial begin
    @(negedge clock);
    test_reset();
    test_if_alone();
    test_mem_write();
    test_contention();
    test_back_to_back();
    test_reset_mid_busy();
    tests_run++;
    if (gnt_q.size() != 0 || if_q.size() != 0 || mem_q.size() != 0) begin
      tests_failed++;
      $display("FAIL scoreboard_drain: got %0d/%0d/%0d pending, required 0/0/0",
               gnt_q.size(), if_q.size(), mem_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion by 200000, required earlier finish");
    $fatal(1, "watchdog expired");
  end

endmodule
